// File: rtl/secuenciador_notas.sv
// Melody sequencer: plays a fixed note table, inserts a silent gap after every note, pulses done at the end.
// Optional SECUENCIA_LOOP_EN adds a `loop` input that restarts the melody instead of finishing.
module secuenciador_notas #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 20,
    parameter int ADDR_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                play,
    input  logic                stop,
`ifdef SECUENCIA_LOOP_EN
    input  logic                loop,
`endif
    output logic signed [31:0]  freq,
    output logic                busy,
    output logic [ADDR_W-1:0]   note_idx,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Handshake: play is a level request sampled only in IDLE; stop is a synchronous abort that
    // wins over everything else; done is a single-cycle pulse with no acknowledge.

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [PW-1:0]      presc, presc_n;
    logic [15:0]        cnt, cnt_n;
    logic signed [31:0] freq_n;
    logic               busy_n, done_n;
    logic [ADDR_W-1:0]  idx_n;

    logic               tick;
    logic               advance;
    logic               loop_req;
    logic [ADDR_W-1:0]  adv_idx;
    logic [31:0]        adv_entry;
    logic [31:0]        first_entry;
    logic               adv_end;

    // Entry format: {freq Hz [31:16], duration ticks [15:0]}; duration 0 marks the end.
    function automatic logic [31:0] rom_entry(input logic [ADDR_W-1:0] a);
        logic [31:0] e;
        e = '0;
        case (32'(a))
            32'd0:   e = {16'd1174, 16'd250};
            32'd1:   e = {16'd988,  16'd250};
            32'd2:   e = {16'd880,  16'd500};
            32'd3:   e = {16'd0,    16'd125};
            default: e = '0;
        endcase
        return e;
    endfunction

`ifdef SECUENCIA_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    assign state_dbg = state;

    always_comb begin
        state_n = state;
        presc_n = presc;
        cnt_n   = cnt;
        freq_n  = freq;
        busy_n  = busy;
        done_n  = 1'b0;
        idx_n   = note_idx;
        advance = 1'b0;

        tick        = (presc == PRESC_LAST);
        adv_idx     = note_idx + ADDR_W'(1);
        adv_entry   = rom_entry(adv_idx);
        first_entry = rom_entry('0);
        // The last address has no successor, so it behaves as if followed by an end marker.
        adv_end     = (note_idx == IDX_LAST) || (adv_entry[15:0] == 16'd0);

        case (state)
            S_IDLE: begin
                freq_n = '0;
                busy_n = 1'b0;
                if (play) begin
                    idx_n   = '0;
                    presc_n = '0;
                    if (first_entry[15:0] == 16'd0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_NOTE;
                        freq_n  = $signed({16'd0, first_entry[31:16]});
                        cnt_n   = first_entry[15:0];
                        busy_n  = 1'b1;
                    end
                end
            end
            S_NOTE: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (cnt == 16'd1) begin
                        if (GAP_TICKS > 0) begin
                            state_n = S_GAP;
                            freq_n  = '0;
                            cnt_n   = 16'(GAP_TICKS);
                            presc_n = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
            end
            S_GAP: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (cnt == 16'd1) begin
                        advance = 1'b1;
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                freq_n  = '0;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (advance) begin
            presc_n = '0;
            if (!adv_end) begin
                state_n = S_NOTE;
                idx_n   = adv_idx;
                freq_n  = $signed({16'd0, adv_entry[31:16]});
                cnt_n   = adv_entry[15:0];
                busy_n  = 1'b1;
            end else if (loop_req && (first_entry[15:0] != 16'd0)) begin
                state_n = S_NOTE;
                idx_n   = '0;
                freq_n  = $signed({16'd0, first_entry[31:16]});
                cnt_n   = first_entry[15:0];
                busy_n  = 1'b1;
            end else begin
                state_n = S_DONE;
                // On overflow the index stays at the last address rather than wrapping to 0.
                idx_n   = (note_idx == IDX_LAST) ? note_idx : adv_idx;
                freq_n  = '0;
                cnt_n   = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
        end

        if (stop) begin
            state_n = S_IDLE;
            presc_n = '0;
            cnt_n   = '0;
            freq_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            idx_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            presc    <= '0;
            cnt      <= '0;
            freq     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            cnt      <= cnt_n;
            freq     <= freq_n;
            busy     <= busy_n;
            done     <= done_n;
            note_idx <= idx_n;
        end
    end

endmodule
